// File: rtl/soc_mem_pkg.sv
// Shared definitions for the data-memory responder: FSM states, default
// window base, word/byte-lane geometry and the wait-counter width helper.
package soc_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h0000_0000;
  localparam int          WORD_W            = 32;
  localparam int          BYTE_W            = 8;
  localparam int          NUM_LANES         = WORD_W / BYTE_W;

  // Width needed to hold 0..wait_cycles, never narrower than one bit.
  function automatic int cnt_width(input int wait_cycles);
    return (wait_cycles < 1) ? 1 : $clog2(wait_cycles + 1);
  endfunction

endpackage

// File: rtl/bytewen_ram.sv
// Word-organised RAM with one write enable per byte lane and a registered
// read port. Each lane is its own byte-wide array so every lane maps onto a
// plain inferred block RAM. Contents and read register are not reset.
module bytewen_ram
  import soc_mem_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic                 clk,
  input  logic [NUM_LANES-1:0] i_we,
  input  logic [ADDR_W-1:0]    i_waddr,
  input  logic [WORD_W-1:0]    i_wdata,
  input  logic                 i_re,
  input  logic [ADDR_W-1:0]    i_raddr,
  output logic [WORD_W-1:0]    o_rdata
);

  localparam int DEPTH = 2 ** ADDR_W;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_LANES; gi = gi + 1) begin : g_lane
      logic [BYTE_W-1:0] r_mem [DEPTH];
      logic [BYTE_W-1:0] r_q;

      // Byte-lane write and registered read; read data holds when i_re is low.
      always_ff @(posedge clk) begin
        if (i_we[gi]) begin
          r_mem[i_waddr] <= i_wdata[gi*BYTE_W +: BYTE_W];
        end
        if (i_re) begin
          r_q <= r_mem[i_raddr];
        end
      end

      assign o_rdata[gi*BYTE_W +: BYTE_W] = r_q;
    end
  endgenerate

endmodule

// File: rtl/data_sram_responder.sv
// Responder end of the CPU data-memory port. Accepts one access at a time,
// inserts WAIT_CYCLES wait states, then completes the access in a single
// DONE cycle. Accesses outside the aligned window return zero and raise a
// one-cycle mem_addr_err instead of touching the RAM.
module data_sram_responder
  import soc_mem_pkg::*;
#(
  parameter int          ADDR_W      = 10,
  parameter logic [31:0] BASE_ADDR   = DEFAULT_BASE_ADDR,
  parameter int          WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        mem_en,
  input  logic [3:0]  mem_wen,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        mem_stall,
  output logic        mem_addr_err
);

  localparam int CW      = cnt_width(WAIT_CYCLES);
  localparam int TAG_LSB = ADDR_W + 2;

  state_t            r_state;
  state_t            w_state_next;
  logic [CW-1:0]     r_cnt;
  logic [31:2]       r_addr;
  logic [3:0]        r_wen;
  logic [31:0]       r_wdata;
  logic              r_rdata_from_ram;
  logic              r_addr_err;

  logic              w_accept;
  logic              w_to_done;
  logic [31:2]       w_acc_addr;
  logic [3:0]        w_acc_wen;
  logic [31:0]       w_acc_wdata;
  logic              w_hit;
  logic              w_is_read;
  logic [ADDR_W-1:0] w_index;
  logic [3:0]        w_ram_we;
  logic              w_ram_re;
  logic [31:0]       w_ram_q;
  logic              w_unused_addr_lsbs;

  // Byte offset within the word has no effect on a word-wide access.
  assign w_unused_addr_lsbs = ^mem_addr[1:0];

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic: DONE always lasts exactly one cycle.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (mem_en) begin
          w_state_next = (WAIT_CYCLES == 0) ? DONE : WAIT;
        end
      end
      WAIT: begin
        if (r_cnt == CW'(1)) begin
          w_state_next = DONE;
        end
      end
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // FSM outputs; everything is gated off while reset is held so no stall is
  // shown and no RAM write can slip through during reset.
  always_comb begin
    mem_stall = 1'b0;
    w_accept  = 1'b0;
    w_to_done = 1'b0;
    if (resetn) begin
      case (r_state)
        IDLE: begin
          mem_stall = mem_en;
          w_accept  = mem_en;
          w_to_done = mem_en && (WAIT_CYCLES == 0);
        end
        WAIT: begin
          mem_stall = 1'b1;
          w_to_done = (r_cnt == CW'(1));
        end
        default: ;
      endcase
    end
  end

  // Wait-state counter: loaded on accept, counts down while waiting.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_cnt <= '0;
    end else if (w_accept) begin
      r_cnt <= CW'(WAIT_CYCLES);
    end else if (r_state == WAIT) begin
      r_cnt <= r_cnt - CW'(1);
    end
  end

  // Latch the request so the CPU may drop mem_en during the wait states.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_addr  <= '0;
      r_wen   <= '0;
      r_wdata <= '0;
    end else if (w_accept) begin
      r_addr  <= mem_addr[31:2];
      r_wen   <= mem_wen;
      r_wdata <= mem_wdata;
    end
  end

  // With zero wait states the access completes straight from IDLE, so the
  // live request is used; otherwise the latched copy is.
  assign w_acc_addr  = (r_state == IDLE) ? mem_addr[31:2] : r_addr;
  assign w_acc_wen   = (r_state == IDLE) ? mem_wen        : r_wen;
  assign w_acc_wdata = (r_state == IDLE) ? mem_wdata      : r_wdata;

  assign w_hit     = (w_acc_addr[31:TAG_LSB] == BASE_ADDR[31:TAG_LSB]);
  assign w_index   = w_acc_addr[TAG_LSB-1:2];
  assign w_is_read = (w_acc_wen == 4'b0000);

  assign w_ram_we  = (w_to_done && w_hit) ? w_acc_wen : 4'b0000;
  assign w_ram_re  = w_to_done && w_hit && w_is_read;

  bytewen_ram #(
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_ram_we),
    .i_waddr (w_index),
    .i_wdata (w_acc_wdata),
    .i_re    (w_ram_re),
    .i_raddr (w_index),
    .o_rdata (w_ram_q)
  );

  // Result tracking: the RAM read register already holds the last read word,
  // so only remember whether the visible data is that word or zero.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_rdata_from_ram <= 1'b0;
      r_addr_err       <= 1'b0;
    end else begin
      r_addr_err <= w_to_done && !w_hit;
      if (w_to_done) begin
        if (!w_hit) begin
          r_rdata_from_ram <= 1'b0;
        end else if (w_is_read) begin
          r_rdata_from_ram <= 1'b1;
        end
      end
    end
  end

  assign mem_rdata    = r_rdata_from_ram ? w_ram_q : 32'h0;
  assign mem_addr_err = r_addr_err;

endmodule

// File: tb/tb_data_sram_responder.sv
`timescale 1ns/1ps
module tb_data_sram_responder;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        resetn;
  logic        en, z_en;
  logic [3:0]  wen, z_wen;
  logic [31:0] addr, wdata, z_addr, z_wdata;
  logic [31:0] rdata, z_rdata;
  logic        stall, err, z_stall, z_err;

  int checks   = 0;
  int failures = 0;

  int          n;
  logic [31:0] rd;
  logic        er;

  data_sram_responder #(
    .ADDR_W      (10),
    .BASE_ADDR   (32'h0000_0000),
    .WAIT_CYCLES (2)
  ) dut (
    .clk          (clk),
    .resetn       (resetn),
    .mem_en       (en),
    .mem_wen      (wen),
    .mem_addr     (addr),
    .mem_wdata    (wdata),
    .mem_rdata    (rdata),
    .mem_stall    (stall),
    .mem_addr_err (err)
  );

  data_sram_responder #(
    .ADDR_W      (10),
    .BASE_ADDR   (32'h0000_0000),
    .WAIT_CYCLES (0)
  ) dut0 (
    .clk          (clk),
    .resetn       (resetn),
    .mem_en       (z_en),
    .mem_wen      (z_wen),
    .mem_addr     (z_addr),
    .mem_wdata    (z_wdata),
    .mem_rdata    (z_rdata),
    .mem_stall    (z_stall),
    .mem_addr_err (z_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full CPU-style access on the WAIT_CYCLES=2 instance: hold the request
  // until stall drops, sample results in that cycle, then release.
  task automatic access(input logic [31:0] a, input logic [3:0] w, input logic [31:0] d,
                        output int stall_cyc, output logic [31:0] rd_o, output logic er_o);
    en = 1'b1; addr = a; wen = w; wdata = d;
    stall_cyc = 0;
    @(negedge clk);
    while (stall && stall_cyc < 20) begin
      stall_cyc++;
      @(negedge clk);
    end
    rd_o = rdata;
    er_o = err;
    $display("access addr=%h wen=%b wdata=%h stall_cycles=%0d rdata=%h err=%b",
             a, w, d, stall_cyc, rd_o, er_o);
    tick();
    en = 1'b0; addr = '0; wen = '0; wdata = '0;
  endtask

  initial begin
    resetn = 1'b0;
    en = 1'b1; wen = 4'hF; addr = 32'h10; wdata = 32'h0;
    z_en = 1'b0; z_wen = 4'h0; z_addr = 32'h0; z_wdata = 32'h0;

    // Reset: outputs quiet even with a request asserted.
    repeat (2) tick();
    @(negedge clk);
    check("rst_stall", stall, 1'b0);
    check("rst_rdata", rdata, 32'h0);
    check("rst_err", err, 1'b0);
    tick();
    en = 1'b0; wen = 4'h0; addr = 32'h0;
    resetn = 1'b1;
    tick();

    // Write then read back with two wait states.
    access(32'h10, 4'hF, 32'hDEAD_BEEF, n, rd, er);
    check("wr_stall_cycles", n, 3);
    check("wr_err", er, 1'b0);
    access(32'h10, 4'h0, 32'h0, n, rd, er);
    check("rd_stall_cycles", n, 3);
    check("rd_data", rd, 32'hDEAD_BEEF);
    @(negedge clk);
    check("rd_data_held", rdata, 32'hDEAD_BEEF);
    tick();

    // Byte lanes.
    access(32'h20, 4'hF, 32'h1122_3344, n, rd, er);
    check("wr_keeps_rdata", rd, 32'hDEAD_BEEF);
    access(32'h20, 4'b0101, 32'hAABB_CCDD, n, rd, er);
    access(32'h20, 4'h0, 32'h0, n, rd, er);
    check("lane_merge", rd, 32'h11BB_33DD);

    // Out of window: one past the top of the window, and an aliasing write.
    access(32'h1000, 4'h0, 32'h0, n, rd, er);
    check("oow_rdata", rd, 32'h0);
    check("oow_err", er, 1'b1);
    check("oow_stall_cycles", n, 3);
    @(negedge clk);
    check("oow_err_one_cycle", err, 1'b0);
    tick();
    access(32'h1020, 4'hF, 32'h5555_5555, n, rd, er);
    check("oow_wr_err", er, 1'b1);
    access(32'h23, 4'h0, 32'h0, n, rd, er);
    check("oow_no_write", rd, 32'h11BB_33DD);

    // Request dropped during wait states still completes.
    en = 1'b1; addr = 32'h30; wen = 4'hF; wdata = 32'hCAFE_F00D;
    @(negedge clk);
    check("abandon_c0_stall", stall, 1'b1);
    tick();
    en = 1'b0; addr = 32'h0; wen = 4'h0; wdata = 32'h0;
    @(negedge clk);
    check("abandon_c1_stall", stall, 1'b1);
    tick();
    @(negedge clk);
    check("abandon_c2_stall", stall, 1'b1);
    tick();
    @(negedge clk);
    check("abandon_c3_stall", stall, 1'b0);
    tick();
    access(32'h30, 4'h0, 32'h0, n, rd, er);
    check("abandon_write_landed", rd, 32'hCAFE_F00D);

    // Reset in the middle of a pending write.
    access(32'h40, 4'hF, 32'h1234_5678, n, rd, er);
    en = 1'b1; addr = 32'h40; wen = 4'hF; wdata = 32'hFFFF_FFFF;
    tick();
    resetn = 1'b0;
    @(negedge clk);
    check("rstwait_stall", stall, 1'b0);
    check("rstwait_rdata", rdata, 32'h0);
    check("rstwait_err", err, 1'b0);
    tick();
    en = 1'b0; addr = 32'h0; wen = 4'h0; wdata = 32'h0;
    repeat (2) tick();
    resetn = 1'b1;
    tick();
    @(negedge clk);
    check("rstwait_idle_stall", stall, 1'b0);
    tick();
    access(32'h40, 4'h0, 32'h0, n, rd, er);
    check("rstwait_latency", n, 3);
    check("rstwait_word_kept", rd, 32'h1234_5678);

    // Zero wait states: accept then done, back-to-back every two cycles.
    z_en = 1'b1; z_addr = 32'h8; z_wen = 4'hF; z_wdata = 32'h89AB_CDEF;
    @(negedge clk);
    check("w0_accept_stall", z_stall, 1'b1);
    tick();
    z_wen = 4'h0; z_wdata = 32'h0;
    @(negedge clk);
    check("w0_done_stall", z_stall, 1'b0);
    tick();
    @(negedge clk);
    check("w0_b2b_stall", z_stall, 1'b1);
    tick();
    z_en = 1'b0;
    @(negedge clk);
    check("w0_b2b_done_stall", z_stall, 1'b0);
    check("w0_b2b_rdata", z_rdata, 32'h89AB_CDEF);
    $display("w0 access addr=%h rdata=%h", 32'h8, z_rdata);
    tick();
    z_en = 1'b1; z_addr = 32'h1000;
    @(negedge clk);
    check("w0_oow_stall", z_stall, 1'b1);
    tick();
    z_en = 1'b0; z_addr = 32'h0;
    @(negedge clk);
    check("w0_oow_err", z_err, 1'b1);
    check("w0_oow_rdata", z_rdata, 32'h0);
    $display("w0 access addr=%h rdata=%h err=%b", 32'h1000, z_rdata, z_err);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
